// File: rtl/mux_scan_sequencer.sv
// Scan controller for the 8:1 mux stage. It steps the select lines through each
// enabled channel, waits out the dwell time, samples y and packs the eight
// samples into one byte. Masked channels are skipped with no cycle cost.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic               s0,
    output logic               s1,
    output logic               s2,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [7:0]         data_out
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         ch, ch_nxt;
    logic [7:0]         mask_q, mask_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [7:0]         shadow, shadow_nxt;
    logic [7:0]         data_nxt;
    logic               done_nxt;
    logic [3:0]         first_hit;
    logic [3:0]         next_hit;

    // Lowest set bit of m at or above index lo; returns {found, index}.
    // lo is 4 bits so "one past channel 7" (8) finds nothing.
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign first_hit = find_from(chan_mask, 4'd0);
    assign next_hit  = find_from(mask_q, {1'b0, ch} + 4'd1);

    assign {s2, s1, s0} = ch;
    assign busy         = (state != IDLE);
    // Enable drops immediately while paused so the mux is quiet.
    assign en           = busy && !pause;

    // Next-state logic: scan sequencing, sample capture and result hand-off.
    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        mask_nxt   = mask_q;
        dwell_nxt  = dwell_q;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        data_nxt   = data_out;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt   = chan_mask;
                    dwell_nxt  = dwell;
                    shadow_nxt = '0;
                    cnt_nxt    = '0;
                    if (first_hit[3]) begin
                        state_nxt = DRIVE;
                        ch_nxt    = first_hit[2:0];
                    end else begin
                        // Nothing to scan: report an empty result right away.
                        done_nxt = 1'b1;
                        data_nxt = 8'h00;
                    end
                end
            end
            DRIVE: begin
                if (!pause) begin
                    if (cnt == dwell_q) state_nxt = SAMPLE;
                    else                cnt_nxt   = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                if (!pause) begin
                    shadow_nxt[ch] = y_in;
                    if (next_hit[3]) begin
                        state_nxt = DRIVE;
                        ch_nxt    = next_hit[2:0];
                        cnt_nxt   = '0;
                    end else begin
                        // Last channel: publish including the bit just taken.
                        state_nxt = IDLE;
                        data_nxt  = shadow_nxt;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ch       <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
            cnt      <= '0;
            shadow   <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ch       <= ch_nxt;
            mask_q   <= mask_nxt;
            dwell_q  <= dwell_nxt;
            cnt      <= cnt_nxt;
            shadow   <= shadow_nxt;
            data_out <= data_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural mux drives y_in, and a
// progress-counting model predicts channel, busy, en, done and result.
module tb_mux_scan_sequencer;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [7:0]    chan_mask = 8'h00;
    logic [DW-1:0] dwell = '0;
    logic          y_in;
    logic          s0, s1, s2, en, busy, done;
    logic [7:0]    data_out;
    logic [7:0]    x = 8'h00;
    logic [2:0]    sel;

    int n_chk  = 0;
    int n_fail = 0;

    mux_scan_sequencer #(.DWELL_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .chan_mask(chan_mask), .dwell(dwell), .y_in(y_in),
        .s0(s0), .s1(s1), .s2(s2), .en(en), .busy(busy), .done(done),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Behavioural 8:1 mux with enable.
    assign sel  = {s2, s1, s0};
    assign y_in = en ? x[sel] : 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Runs one scan starting from a negedge. The model counts unpaused busy
    // edges (progress p); each channel takes dwell+2 of them, so the current
    // channel is the (p / (dwell+2))-th enabled one. Returns at the negedge
    // of the done cycle so a caller can chain the next start with no gap.
    task automatic run_scan(input logic [7:0] m, input logic [3:0] d, input logic [7:0] xv,
                            input int ps, input int pl, input bit rnd_pause, input int bsa,
                            output logic [7:0] got_data, output int got_lat);
        int list[$];
        int total, per, p, t;
        bit pz;
        list = {};
        for (int i = 0; i < 8; i++) if (m[i]) list.push_back(i);
        per   = int'(d) + 2;
        total = list.size() * per;
        got_data = 8'hxx;
        got_lat  = -1;
        chan_mask = m; dwell = d; x = xv; start = 1'b1; pause = 1'b0;
        @(posedge clk);
        p = 0; t = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            // Mid-scan config changes must be ignored.
            chan_mask = 8'($urandom);
            dwell     = 4'($urandom);
            if (p == total) begin
                chk("done", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                chk("data_out", 32'(data_out), 32'(xv & m));
                pause = 1'($urandom);
                #1 chk("en_idle", 32'(en), 32'd0);
                got_data = data_out;
                got_lat  = t;
                break;
            end
            chk("done_low", 32'(done), 32'd0);
            chk("busy", 32'(busy), 32'd1);
            chk("sel", 32'(sel), 32'(list[p / per]));
            pz = rnd_pause ? ($urandom_range(0, 3) == 0) : (t >= ps && t < ps + pl);
            pause = pz;
            if (t == bsa) start = 1'b1;
            #1 chk("en", 32'(en), 32'(!pz));
            @(posedge clk);
            if (!pz) p++;
            t++;
            if (t > total + 400) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: no done after %0d cycles, expected %0d", t, total);
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start = 1'b0;
        pause = 1'($urandom);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        #1 chk("idle_en", 32'(en), 32'd0);
    endtask

    typedef struct {
        logic [7:0] mask;
        logic [3:0] dw;
        logic [7:0] xv;
        int         ps;
        int         pl;
        int         bsa;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] gd, m, xv;
        int         gl;

        tbl[0] = '{8'hFF, 4'd0,  8'hA5, -1, 0, -1, 8'hA5, 16};
        tbl[1] = '{8'h0F, 4'd2,  8'hFF, -1, 0, -1, 8'h0F, 16};
        tbl[2] = '{8'hFF, 4'd1,  8'h3C,  9, 5, -1, 8'h3C, 29};
        tbl[3] = '{8'h00, 4'd5,  8'hFF, -1, 0, -1, 8'h00, 0};
        tbl[4] = '{8'h81, 4'd3,  8'hFF, -1, 0, -1, 8'h81, 10};
        tbl[5] = '{8'h50, 4'd15, 8'hF0, -1, 0,  4, 8'h50, 34};

        // Reset state.
        #2;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_scan(tbl[i].mask, tbl[i].dw, tbl[i].xv, tbl[i].ps, tbl[i].pl, 1'b0,
                     tbl[i].bsa, gd, gl);
            chk($sformatf("vec%0d_data", i), 32'(gd), 32'(tbl[i].exp_data));
            chk($sformatf("vec%0d_lat", i), 32'(gl), 32'(tbl[i].exp_lat));
            idle_cycle();
        end

        // Asynchronous reset while on channel 4.
        chan_mask = 8'hFF; dwell = 4'd0; x = 8'h5A; start = 1'b1; pause = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            k = 0;
            while (sel != 3'd4 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("reach_ch4", 32'(sel), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_en", 32'(en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_data", 32'(data_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(8'hFF, 4'd0, 8'h81, -1, 0, 1'b0, -1, gd, gl);
        chk("post_rst_data", 32'(gd), 32'h81);
        chk("post_rst_lat", 32'(gl), 32'd16);
        idle_cycle();

        // Start while busy is ignored; start on the done cycle chains directly.
        run_scan(8'hFF, 4'd0, 8'hA5, -1, 0, 1'b0, 3, gd, gl);
        chk("b2b_first_data", 32'(gd), 32'hA5);
        chk("b2b_first_lat", 32'(gl), 32'd16);
        run_scan(8'h3C, 4'd1, 8'hC3, -1, 0, 1'b0, -1, gd, gl);
        chk("b2b_second_data", 32'(gd), 32'h00);
        chk("b2b_second_lat", 32'(gl), 32'd12);
        idle_cycle();

        // Randomized scans with random pauses, sometimes chained.
        for (int r = 0; r < 25; r++) begin
            m  = 8'($urandom);
            xv = 8'($urandom);
            run_scan(m, 4'($urandom_range(0, 3)), xv, -1, 0, 1'b1, -1, gd, gl);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
